shift_rows_pipe: RTL and testbench
==================================

// Module: shift_rows_pipe
// PURPOSE
//   Registered, parametrised ShiftRows / InvShiftRows stage for the AES/Rijndael datapath.
//   Supports Rijndael block widths Nb = 4/6/8 columns. Direction is selected per transfer.
//   A 2-entry output buffer carries valid/ready backpressure, so the stage can sit between
//   SubBytes and MixColumns in a pipelined round. Successor to the fixed 128-bit InvShiftRows.
// PARAMETERS
//   NB     4   state columns; legal values 4, 6, 8 (block width 32*NB bits)
//   TAG_W  4   width of the sideband tag passed through unchanged alongside each state
// PORTS
//   clk       in   1        rising-edge clock
//   rst       in   1        asynchronous, active-high reset
//   in_valid  in   1        input beat valid
//   in_ready  out  1        stage can accept a beat this cycle
//   in_inv    in   1        0 = ShiftRows (left), 1 = InvShiftRows (right); sampled with beat
//   in_tag    in   TAG_W    sideband tag, e.g. round number
//   in_data   in   32*NB    state, column-major: byte k = s[k%4][k/4]; byte 0 = MSB [32*NB-1 -: 8]
//   out_valid out  1        output beat valid
//   out_ready in   1        downstream accepts beat
//   out_tag   out  TAG_W    tag of the output beat
//   out_data  out  32*NB    shifted state, same byte order as in_data
// BEHAVIOUR
//   - Row shift offsets C(r) for r = 0..3:
//       NB = 4 or 6: 0,1,2,3.   NB = 8: 0,1,3,4.
//     Forward:  out s[r][c] = in s[r][(c+C(r)) mod NB].
//     Inverse:  out s[r][c] = in s[r][(c-C(r)+NB) mod NB].
//     Row 0 is never moved.
//   - Handshake
//       Input transfer:  in_valid & in_ready.
//       Output transfer: out_valid & out_ready.
//       in_ready = (count < 2). It is a register-only function and never depends on in_valid.
//   - Buffer
//       Transform is applied combinationally on input; the result plus tag is written into
//       a 2-entry FIFO.
//       count 0..2: push increments, pop decrements, push and pop together hold count.
//       out_valid = (count != 0); out_data/out_tag = head entry.
//   - Latency: a beat accepted at edge N is presented at out_* immediately after edge N.
//     Full throughput is 1 beat/clk while out_ready stays high.
//   - Ordering: strict FIFO. The direction and tag of each beat stay bound to that beat.
//   - Full: at count == 2, in_ready = 0 and in_valid is ignored. A simultaneous pop frees
//     a slot only from the next cycle.
//   - Empty: at count == 0, out_valid = 0. out_data holds the last value and is don't-care.
//   - Output stability: while out_valid & !out_ready, out_data and out_tag must hold stable.
//   - Pointer wrap: read/write pointers are 1 bit each and wrap modulo 2.
//   - Reset, applied asynchronously at any time, including mid-transfer:
//       count = 0, pointers = 0, out_valid = 0, in_ready = 1 after release,
//       storage = 0 so out_data = 0 and out_tag = 0. In-flight beats are discarded.
//   - Illegal NB: elaboration must fail via a generate-time check.
// STRUCTURE
//   - aes_pkg (shared package):
//       function row_shift(nb, r) returning C(r);
//       byte-index helper idx(r, c) for the column-major layout;
//       constant AES_NB = 4.
//   - Sub-module shift_rows_core: combinational permutation with ports nb-parameter, inv,
//     in, out. It is reused by the key-schedule and debug paths.
//     shift_rows_pipe = shift_rows_core + 2-entry FIFO + handshake.
// TESTING
//   1. NB=4, fwd, in_data=d4bf5d30_e0b452ae_b84111f1_1e2798e5, out_ready=1
//      -> next cycle out_data=d4b411e5_e0419830_b8275dae_1ebf52f1.
//   2. NB=4, inv, in_data=d4b411e5_e0419830_b8275dae_1ebf52f1
//      -> out_data=d4bf5d30_e0b452ae_b84111f1_1e2798e5.
//      Back-to-back fwd/inv beats keep their own modes.
//   3. NB=8, fwd, bytes 00..1f ascending -> row3 comes out rotated by 4 and row2 by 3.
//      Example: out byte 2 = 0e, out byte 3 = 13. fwd then inv round-trips to the input.
//   4. out_ready=0, 3 beats offered
//      -> 2 accepted, in_ready=0 on the 3rd. out_data is held stable.
//      Raise out_ready -> beats emerge in order and the 3rd is accepted one cycle after the
//      first pop.
//   5. Random in_valid/out_ready for 10k beats with a reference model
//      -> no loss, duplication or reordering, and tags match.
//   6. rst pulsed mid-stream with count=2 -> out_valid=0 and out_data=0 asynchronously.
//      in_ready=1 after release. No stale beat appears afterwards.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES/Rijndael helpers: row shift offsets and the column-major byte index.
package aes_pkg;

  localparam int AES_NB = 4;

  // Rijndael row offsets: 0,1,2,3 for 4/6 columns, 0,1,3,4 for 8 columns.
  function automatic int row_shift(input int nb, input int r);
    return ((nb == 8) && (r >= 2)) ? r + 1 : r;
  endfunction

  // Byte number of s[r][c]; byte 0 sits at the MSB end of the state.
  function automatic int idx(input int r, input int c);
    return 4 * c + r;
  endfunction

endpackage

// File: rtl/shift_rows_core.sv
// Combinational ShiftRows / InvShiftRows byte permutation for an NB-column state.
module shift_rows_core
  import aes_pkg::*;
#(
  parameter int NB = AES_NB
) (
  input  logic              inv,
  input  logic [32*NB-1:0]  in,
  output logic [32*NB-1:0]  out
);

  localparam int W = 32 * NB;

  if (!((NB == 4) || (NB == 6) || (NB == 8))) begin : g_illegal_nb
    $error("shift_rows_core: NB must be 4, 6 or 8");
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_row
    for (genvar gj = 0; gj < NB; gj++) begin : g_col
      localparam int SH  = row_shift(NB, gi);
      localparam int DST = idx(gi, gj);
      localparam int FWD = idx(gi, (gj + SH) % NB);
      localparam int INV = idx(gi, (gj - SH + NB) % NB);
      assign out[W-1-8*DST -: 8] = inv ? in[W-1-8*INV -: 8] : in[W-1-8*FWD -: 8];
    end
  end

endmodule

// File: rtl/shift_rows_pipe.sv
// ShiftRows stage: permutation on the input side, then a 2-entry FIFO with
// valid/ready on both sides. in_ready depends only on the occupancy register.
module shift_rows_pipe
  import aes_pkg::*;
#(
  parameter int NB    = AES_NB,
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_inv,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic [32*NB-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TAG_W-1:0]  out_tag,
  output logic [32*NB-1:0]  out_data
);

  localparam int W = 32 * NB;

  logic [W-1:0]     shifted;
  logic [W-1:0]     data_q [2];
  logic [TAG_W-1:0] tag_q  [2];
  logic [1:0]       count_q, count_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic             push, pop;

  shift_rows_core #(.NB(NB)) u_core (
    .inv (in_inv),
    .in  (in_data),
    .out (shifted)
  );

  assign in_ready  = (count_q < 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_data  = data_q[rd_ptr_q];
  assign out_tag   = tag_q[rd_ptr_q];

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is cleared on reset so an empty stage presents all-zero data and tag.
  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        data_q[gi] <= '0;
        tag_q[gi]  <= '0;
      end else if (push && (wr_ptr_q == gi[0])) begin
        data_q[gi] <= shifted;
        tag_q[gi]  <= in_tag;
      end
    end
  end

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Scoreboard bench for shift_rows_pipe with NB=4 and NB=8 instances.
module tb_shift_rows_pipe;

  typedef struct {
    logic [3:0]   tag;
    logic [255:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // NB=4 instance
  logic         in_valid4 = 0, in_inv4 = 0, out_ready4 = 0;
  logic [3:0]   in_tag4 = 0;
  logic [127:0] in_data4 = 0;
  logic         in_ready4, out_valid4;
  logic [3:0]   out_tag4;
  logic [127:0] out_data4;

  // NB=8 instance
  logic         in_valid8 = 0, in_inv8 = 0, out_ready8 = 1;
  logic [3:0]   in_tag8 = 0;
  logic [255:0] in_data8 = 0;
  logic         in_ready8, out_valid8;
  logic [3:0]   out_tag8;
  logic [255:0] out_data8;

  shift_rows_pipe #(.NB(4), .TAG_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .in_inv(in_inv4),
    .in_tag(in_tag4), .in_data(in_data4), .out_valid(out_valid4), .out_ready(out_ready4),
    .out_tag(out_tag4), .out_data(out_data4)
  );

  shift_rows_pipe #(.NB(8), .TAG_W(4)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .in_inv(in_inv8),
    .in_tag(in_tag8), .in_data(in_data8), .out_valid(out_valid8), .out_ready(out_ready8),
    .out_tag(out_tag8), .out_data(out_data8)
  );

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t q4[$];
  exp_t q8[$];
  bit   rand_or4 = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: unpack into a 4 x nb matrix, rotate each row, repack.
  function automatic logic [255:0] ref_shift(input int nb, input bit inv, input logic [255:0] din);
    logic [7:0]   s [4][8];
    logic [255:0] res;
    int           offs [4];
    int           src;
    res = '0;
    offs = (nb == 8) ? '{0, 1, 3, 4} : '{0, 1, 2, 3};
    for (int c = 0; c < nb; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = din[32*nb-1-8*(4*c+r) -: 8];
    for (int c = 0; c < nb; c++)
      for (int r = 0; r < 4; r++) begin
        src = inv ? (c - offs[r] + nb) % nb : (c + offs[r]) % nb;
        res[32*nb-1-8*(4*c+r) -: 8] = s[r][src];
      end
    return res;
  endfunction

  // Monitor for NB=4: occupancy, stability, ordering.
  logic [127:0] prev_data4;
  logic [3:0]   prev_tag4;
  bit           prev_stall4 = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q4.delete();
      prev_stall4 = 0;
    end else begin
      chk("in_ready4", {255'b0, in_ready4}, {255'b0, (q4.size() < 2)});
      chk("out_valid4", {255'b0, out_valid4}, {255'b0, (q4.size() != 0)});
      if (prev_stall4) begin
        chk("hold_data4", {128'b0, out_data4}, {128'b0, prev_data4});
        chk("hold_tag4", {252'b0, out_tag4}, {252'b0, prev_tag4});
      end
      if (out_valid4 && out_ready4) begin
        if (q4.size() == 0) begin
          chk("unexpected_beat4", 256'd1, 256'd0);
        end else begin
          e = q4.pop_front();
          chk("out_data4", {128'b0, out_data4}, e.data);
          chk("out_tag4", {252'b0, out_tag4}, {252'b0, e.tag});
        end
      end
      if (in_valid4 && in_ready4) begin
        e.tag  = in_tag4;
        e.data = ref_shift(4, in_inv4, {128'b0, in_data4});
        q4.push_back(e);
      end
      prev_stall4 = out_valid4 && !out_ready4;
      prev_data4  = out_data4;
      prev_tag4   = out_tag4;
    end
  end

  // Monitor for NB=8.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q8.delete();
    end else begin
      chk("out_valid8", {255'b0, out_valid8}, {255'b0, (q8.size() != 0)});
      if (out_valid8 && out_ready8) begin
        if (q8.size() == 0) begin
          chk("unexpected_beat8", 256'd1, 256'd0);
        end else begin
          e = q8.pop_front();
          chk("out_data8", out_data8, e.data);
          chk("out_tag8", {252'b0, out_tag8}, {252'b0, e.tag});
        end
      end
      if (in_valid8 && in_ready8) begin
        e.tag  = in_tag8;
        e.data = ref_shift(8, in_inv8, in_data8);
        q8.push_back(e);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_or4) out_ready4 = ($urandom_range(0, 3) != 0);
    end
  end

  // Present one beat and hold it until accepted; returns at edge+1 after acceptance.
  task automatic send4(input bit inv, input logic [3:0] tag, input logic [127:0] d);
    bit acc;
    int w = 0;
    in_valid4 = 1; in_inv4 = inv; in_tag4 = tag; in_data4 = d;
    forever begin
      @(negedge clk);
      acc = in_ready4;
      @(posedge clk);
      #1;
      if (acc) break;
      w++;
      if (w > 1000) begin
        chk("send4_timeout", 256'd1, 256'd0);
        break;
      end
    end
    in_valid4 = 0;
  endtask

  task automatic send8(input bit inv, input logic [3:0] tag, input logic [255:0] d);
    bit acc;
    int w = 0;
    in_valid8 = 1; in_inv8 = inv; in_tag8 = tag; in_data8 = d;
    forever begin
      @(negedge clk);
      acc = in_ready8;
      @(posedge clk);
      #1;
      if (acc) break;
      w++;
      if (w > 1000) begin
        chk("send8_timeout", 256'd1, 256'd0);
        break;
      end
    end
    in_valid8 = 0;
  endtask

  task automatic drain4();
    int w = 0;
    while (q4.size() != 0 && w < 200) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("drain4_empty", {224'b0, q4.size()}, 256'd0);
  endtask

  localparam logic [127:0] V_IN  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
  localparam logic [127:0] V_OUT = 128'hd4b411e5_e0419830_b8275dae_1ebf52f1;

  initial begin
    logic [255:0] ramp, fwd8;
    #12;
    chk("rst_out_valid", {255'b0, out_valid4}, 256'd0);
    chk("rst_in_ready", {255'b0, in_ready4}, 256'd1);
    chk("rst_out_data", {128'b0, out_data4}, 256'd0);
    chk("rst_out_tag", {252'b0, out_tag4}, 256'd0);
    @(posedge clk); #1; rst = 0;

    // Known vectors, forward then inverse
    out_ready4 = 1;
    send4(0, 4'h1, V_IN);
    chk("vec_fwd_valid", {255'b0, out_valid4}, 256'd1);
    chk("vec_fwd_data", {128'b0, out_data4}, {128'b0, V_OUT});
    @(posedge clk); #1;
    send4(1, 4'h2, V_OUT);
    chk("vec_inv_data", {128'b0, out_data4}, {128'b0, V_IN});
    send4(0, 4'h3, V_IN);
    send4(1, 4'h4, V_IN);
    send4(1, 4'h5, V_OUT);
    send4(0, 4'h6, V_OUT);
    drain4();

    // Backpressure: two beats fill the buffer, third waits for a pop
    out_ready4 = 0;
    send4(0, 4'hA, 128'h00112233_44556677_8899aabb_ccddeeff);
    send4(1, 4'hB, 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0);
    in_valid4 = 1; in_inv4 = 0; in_tag4 = 4'hC; in_data4 = V_IN;
    @(negedge clk);
    chk("full_in_ready", {255'b0, in_ready4}, 256'd0);
    repeat (3) @(posedge clk);
    #1; out_ready4 = 1;
    @(posedge clk); #1;
    chk("slot_after_pop", {255'b0, in_ready4}, 256'd1);
    @(posedge clk); #1;
    in_valid4 = 0;
    drain4();

    // NB=8 ramp, known byte positions and round trip
    for (int k = 0; k < 32; k++) ramp[255-8*k -: 8] = 8'(k);
    fwd8 = ref_shift(8, 0, ramp);
    send8(0, 4'h7, ramp);
    chk("nb8_byte2", {248'b0, out_data8[255-16 -: 8]}, {248'b0, 8'h0e});
    chk("nb8_byte3", {248'b0, out_data8[255-24 -: 8]}, {248'b0, 8'h13});
    send8(1, 4'h8, fwd8);
    chk("nb8_roundtrip", out_data8, ramp);
    for (int i = 0; i < 300; i++)
      send8(1'($urandom), 4'($urandom),
            {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("drain8_empty", {224'b0, q8.size()}, 256'd0);

    // Random traffic on NB=4
    rand_or4 = 1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      send4(1'($urandom), 4'($urandom), {$urandom, $urandom, $urandom, $urandom});
    end
    rand_or4 = 0;
    out_ready4 = 1;
    drain4();

    // Asynchronous reset with the buffer full
    out_ready4 = 0;
    send4(0, 4'hD, V_IN);
    send4(1, 4'hE, V_OUT);
    @(posedge clk); #3;
    rst = 1;
    #1;
    chk("arst_out_valid", {255'b0, out_valid4}, 256'd0);
    chk("arst_out_data", {128'b0, out_data4}, 256'd0);
    chk("arst_out_tag", {252'b0, out_tag4}, 256'd0);
    @(posedge clk); #2;
    rst = 0;
    #1;
    chk("post_rst_in_ready", {255'b0, in_ready4}, 256'd1);
    chk("post_rst_out_valid", {255'b0, out_valid4}, 256'd0);
    out_ready4 = 1;
    for (int i = 0; i < 5; i++)
      send4(1'($urandom), 4'($urandom), {$urandom, $urandom, $urandom, $urandom});
    drain4();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
